// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared codes for the memory pipeline stage
//
// Purpose: write-back source codes, load/store funct3 encodings and the
// memory-stage FSM state type, shared by mem_stage and mem_align.
// Ports: none (package).
package mem_stage_pkg;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane steering, legality check and load extension
//
// Purpose: purely combinational helper for the memory stage.
// Ports:
//   addr_lo_i     byte offset within the word (alu_result[1:0])
//   funct3_i      access size/sign
//   is_store_i    1 for stores, 0 for loads
//   store_data_i  raw store data (rs2)
//   load_raw_i    raw word read from memory
//   be_o          byte enables for the accessed lanes
//   wdata_o       lane-replicated store data
//   misaligned_o  access is misaligned or the funct3 is illegal
//   load_data_o   lane-selected, sign/zero-extended load result
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] load_raw_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [XLEN-1:0] lane_shifted;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign lane_shifted = load_raw_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    load_data_o  = load_raw_i;

    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
    endcase

    if (is_store_i) begin
      if (funct3_i[2]) misaligned_o = 1'b1;
    end else begin
      if (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111)
        misaligned_o = 1'b1;
    end

    case (funct3_i)
      F3_LB:   load_data_o = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
      F3_LBU:  load_data_o = {24'd0, lane_shifted[7:0]};
      F3_LH:   load_data_o = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
      F3_LHU:  load_data_o = {16'd0, lane_shifted[15:0]};
      default: load_data_o = load_raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - load/store pipeline stage with stall on busy memory
//
// Purpose: issues loads/stores on a valid/ready data-memory port, stalls
// upstream while memory is busy, and registers results into write-back.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   alu_result, rs2_data, rd_addr   execute-stage results
//   reg_write, mem_write, funct3,
//   wb_mux                          control from execute
//   forward_mem                     forwarding value back to execute
//   stall                           hold all upstream stages
//   dmem_*                          data-memory request/response port
//   rd_addr_out, reg_write_out,
//   wb_mux_out, alu_out_wb,
//   load_data_wb                    registered write-back fields
//   misalign                        one-cycle pulse for a suppressed access
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [4:0]        rd_addr,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [1:0]        wb_mux,
  output logic [XLEN-1:0]   forward_mem,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  output logic [4:0]        rd_addr_out,
  output logic              reg_write_out,
  output logic [1:0]        wb_mux_out,
  output logic [XLEN-1:0]   alu_out_wb,
  output logic [XLEN-1:0]   load_data_wb,
  output logic              misalign
);

  state_e          state_q, state_d;
  logic            access;
  logic            misaligned;
  logic            bad_access;
  logic [XLEN-1:0] load_ext;

  logic [4:0]      rd_addr_q;
  logic            reg_write_q;
  logic [1:0]      wb_mux_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] load_q;
  logic            misalign_q;

  mem_align #(.XLEN(XLEN)) u_align (
    .addr_lo_i    (alu_result[1:0]),
    .funct3_i     (funct3),
    .is_store_i   (mem_write),
    .store_data_i (rs2_data),
    .load_raw_i   (dmem_rdata),
    .be_o         (dmem_be),
    .wdata_o      (dmem_wdata),
    .misaligned_o (misaligned),
    .load_data_o  (load_ext)
  );

  assign access      = mem_write | (wb_mux == WB_MEM);
  assign bad_access  = access & misaligned;
  assign forward_mem = alu_result;
  assign dmem_addr   = {alu_result[ADDR_W-1:2], 2'b00};
  assign dmem_we     = mem_write & dmem_req;

  // Request/stall are combinational so a zero-wait access completes in
  // the same cycle; rst_n gating drops them the instant reset asserts.
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem_req = access & ~misaligned & rst_n;
        stall    = dmem_req & ~dmem_ready;
        if (stall) state_d = S_WAIT;
      end
      S_WAIT: begin
        dmem_req = rst_n;
        stall    = rst_n & ~dmem_ready;
        if (dmem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      wb_mux_q    <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (stall) begin
        // Bubble into write-back while memory is still busy.
        reg_write_q <= 1'b0;
        wb_mux_q    <= '0;
        misalign_q  <= 1'b0;
      end else begin
        rd_addr_q   <= rd_addr;
        reg_write_q <= reg_write & ~bad_access;
        wb_mux_q    <= wb_mux;
        alu_q       <= alu_result;
        load_q      <= load_ext;
        misalign_q  <= bad_access;
      end
    end
  end

  assign rd_addr_out   = rd_addr_q;
  assign reg_write_out = reg_write_q;
  assign wb_mux_out    = wb_mux_q;
  assign alu_out_wb    = alu_q;
  assign load_data_wb  = load_q;
  assign misalign      = misalign_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes its registered outputs: ALU result/address, store data, rd, funct3, write-back select and write enables.
- Performs loads and stores over a valid/ready data-memory port, with byte-lane steering and sign/zero extension.
- Stalls the pipeline while memory is busy.
- Registers results into the write-back stage and drives the MEM-stage forwarding value back to execute.

Parameters:
- ADDR_W, 32, data-memory byte address width
- XLEN, 32, datapath width; only 32 is supported

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- alu_result  in  XLEN  ALU output from execute; memory byte address for loads/stores
- rs2_data  in  XLEN  store data
- rd_addr  in  5  destination register
- reg_write  in  1  instruction writes rd
- mem_write  in  1  store
- funct3  in  3  access size/sign
- wb_mux  in  2  write-back source; WB_MEM marks a load
- forward_mem  out  XLEN  combinational copy of alu_result for the execute forwarding mux
- stall  out  1  hold all upstream stages
- dmem_req  out  1  request valid
- dmem_we  out  1  write
- dmem_addr  out  ADDR_W  word-aligned address ({alu_result[ADDR_W-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-steered store data
- dmem_rdata  in  XLEN  read data; valid with dmem_ready
- dmem_ready  in  1  request accepted/completed this cycle
- rd_addr_out  out  5  to write-back
- reg_write_out  out  1  to write-back
- wb_mux_out  out  2  to write-back
- alu_out_wb  out  XLEN  registered ALU result
- load_data_wb  out  XLEN  registered, extended load data
- misalign  out  1  one-cycle registered pulse: misaligned or illegal access suppressed

Behaviour:
- access = mem_write | (wb_mux == WB_MEM).
- Misaligned when:
  - half access with alu_result[0]=1, or
  - word access with alu_result[1:0]!=0, or
  - load funct3 in {011,110,111}, or store funct3[2]=1.
- Misaligned access: no dmem_req; next cycle reg_write_out=0, misalign=1.
- FSM with two states:
  - IDLE: dmem_req = access & ~misaligned & rst_n.
    - If dmem_ready in the same cycle: complete, no stall.
    - Otherwise: go to WAIT, stall=1 combinationally.
  - WAIT: dmem_req=1 with identical addr/we/be/wdata. Upstream inputs are held stable by stall.
    - stall=1 until dmem_ready.
    - On dmem_ready: stall=0, complete, return to IDLE.
- Zero-wait completes in the same cycle; each extra memory cycle adds one stall cycle.
- Completion or non-access: on clk, register rd_addr, reg_write, wb_mux, alu_result, load data into the *_out/_wb registers.
- While stalled (WAIT with no ready): reg_write_out=0 and wb_mux_out=0 (bubble to write-back). Other *_wb fields are don't-care.
- Stores:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111.
- Loads: select lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Loads drive be for the accessed lanes as stores do.
- Reset (async, any state including WAIT): state=IDLE; dmem_req, stall, all *_out/_wb, misalign = 0. An in-flight request is abandoned; the memory side must tolerate a dropped req.

Decomposition:
- Shared package (defs): WB_MEM/WB_ALU/WB_PC codes; LB/LH/LW/LBU/LHU and SB/SH/SW funct3 constants; FSM state encodings S_IDLE/S_WAIT.
- One sub-module: mem_align. Purely combinational; produces be, wdata, misaligned and the extended load data from addr[1:0], funct3 and raw data.

Test Plan:
- SW addr 0x100, rs2=0xDEADBEEF, ready held 1 -> req=1, we=1, be=1111, wdata=0xDEADBEEF; no stall; reg_write_out=0 next cycle.
- LB addr 0x103, rdata=0x80xxxxxx, ready=1 -> load_data_wb=0xFFFFFF80. LBU same -> 0x00000080.
- SH addr 0x102, rs2=0x1234, ready=1 -> be=1100, wdata=0x12341234.
- LW with ready low 3 cycles -> stall=1 exactly 3 cycles; req/addr stable throughout; reg_write_out=0 during the stall; load data registered on the 4th edge.
- LW addr 0x101 -> no req, misalign=1 for one cycle, reg_write_out=0.
- rst_n low in WAIT -> stall and req drop immediately; state IDLE; a new SW after release completes normally.
